maxpool_flatten_buffer: RTL and testbench

Upstream neighbour of the flatten/final classification layer. Accepts a binarized 28x28 image as a stream of 4-pixel beats over a valid/ready handshake. It applies 2x2 binary max-pooling (logical OR) and assembles the 14x14 pooled map into a flat 196-bit vector, which drives data_in of the flatten layer. A single output buffer is held until the downstream stage consumes it.

---
 rtl/bnn_pkg.sv | 17 +
 rtl/pool_row_unit.sv | 26 ++
 rtl/maxpool_flatten_buffer.sv | 106 ++++++++++
 tb/tb_maxpool_flatten_buffer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared constants and types for the binarized front end feeding the flatten layer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bnn_pkg;

   localparam int IMG_DIM       = 28;                      // input image side, pixels
   localparam int BEAT_PIX      = 4;                       // pixels per input beat (even)
   localparam int POOLED_DIM    = IMG_DIM / 2;             // pooled map side
   localparam int BEATS_PER_ROW = IMG_DIM / BEAT_PIX;      // beats covering one image row
   localparam int HALF_BEAT     = BEAT_PIX / 2;            // pooled columns produced per beat
   localparam int OUT_BITS      = POOLED_DIM * POOLED_DIM; // flattened pooled map width

   // Flattened pooled map; bit r*POOLED_DIM+c is pooled row r, column c.
   // The flatten layer's data_in uses the same type.
   typedef logic [OUT_BITS-1:0] pooled_vec_t;

endpackage

// File: rtl/pool_row_unit.sv
// 2x2 binary max-pool datapath for one beat: horizontal OR of pixel pairs, then
// vertical OR against the buffered even-row result for the same pooled columns.
// Latency: combinational. Backpressure: none (pure datapath).
// Ports:
//   pix     - BEAT_PIX binary pixels of the current beat
//   row_seg - buffered horizontal-pool bits from the even row above, same columns
//   h_pool  - horizontal pool of this beat (stored when the current row is even)
//   v_pool  - full 2x2 pool result (written to the output map when the row is odd)
module pool_row_unit
   import bnn_pkg::*;
(
   input  logic [BEAT_PIX-1:0]  pix,
   input  logic [HALF_BEAT-1:0] row_seg,
   output logic [HALF_BEAT-1:0] h_pool,
   output logic [HALF_BEAT-1:0] v_pool
);

   always_comb begin
      h_pool = '0;
      for (int j = 0; j < HALF_BEAT; j++) begin
         h_pool[j] = pix[2*j] | pix[2*j+1];
      end
      v_pool = h_pool | row_seg;
   end

endmodule

// File: rtl/maxpool_flatten_buffer.sv
// Streams a binarized 28x28 image in 4-pixel beats, 2x2 OR-pools it and holds the
// flattened 14x14 map for the flatten layer. Latency: out_valid 1 cycle after the last
// accepted beat. Backpressure: in_ready = !out_valid; one frame buffer, no overlap.
// Ports:
//   clock, reset          - rising-edge clock, async active-low reset
//   in_valid/in_ready     - input beat handshake; in_sof marks the first beat of a frame
//   in_pix                - beat pixels, bit k is column beat_idx*BEAT_PIX+k
//   data_out/out_valid    - pooled map and frame-complete flag, held until out_ready
//   out_ready             - downstream consumes the frame on out_valid && out_ready
//   frame_err             - one-cycle pulse when in_sof restarts a partially received frame
module maxpool_flatten_buffer
   import bnn_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   input  logic                in_sof,
   input  logic [BEAT_PIX-1:0] in_pix,
   output logic                in_ready,
   output pooled_vec_t         data_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                frame_err
);

   localparam int BEAT_W = $clog2(BEATS_PER_ROW);
   localparam int ROW_W  = $clog2(IMG_DIM);

   logic [BEAT_W-1:0]     beat_idx;
   logic [ROW_W-1:0]      row_idx;
   logic [POOLED_DIM-1:0] row_buf;

   logic [BEAT_W-1:0]     eff_beat;
   logic [ROW_W-1:0]      eff_row;
   logic [HALF_BEAT-1:0]  row_seg;
   logic [HALF_BEAT-1:0]  h_pool;
   logic [HALF_BEAT-1:0]  v_pool;
   logic                  accept;
   logic                  restart;
   logic                  beat_last;
   logic                  row_last;
   int                    seg_base;
   int                    out_base;

   assign in_ready = !out_valid;

   // A start-of-frame beat is processed as position (0,0) regardless of where the
   // counters were, so the effective position, not the registered one, steers the datapath.
   always_comb begin
      accept    = in_valid && in_ready;
      restart   = accept && in_sof;
      eff_beat  = in_sof ? '0 : beat_idx;
      eff_row   = in_sof ? '0 : row_idx;
      beat_last = (eff_beat == BEAT_W'(BEATS_PER_ROW - 1));
      row_last  = (eff_row == ROW_W'(IMG_DIM - 1));
      seg_base  = int'(eff_beat) * HALF_BEAT;
      out_base  = int'(eff_row >> 1) * POOLED_DIM + seg_base;
      row_seg   = row_buf[seg_base +: HALF_BEAT];
   end

   pool_row_unit u_pool (
      .pix     (in_pix),
      .row_seg (row_seg),
      .h_pool  (h_pool),
      .v_pool  (v_pool)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         beat_idx  <= '0;
         row_idx   <= '0;
         row_buf   <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         // Only a restart that abandons real progress is an error; a sof at (0,0) is normal.
         frame_err <= restart && ((beat_idx != '0) || (row_idx != '0));

         if (accept) begin
            // Even rows park their horizontal pool; odd rows complete the 2x2 window.
            if (!eff_row[0]) begin
               row_buf[seg_base +: HALF_BEAT] <= h_pool;
            end else begin
               data_out[out_base +: HALF_BEAT] <= v_pool;
            end

            if (beat_last) begin
               beat_idx <= '0;
               row_idx  <= row_last ? '0 : eff_row + 1'b1;
            end else begin
               beat_idx <= eff_beat + 1'b1;
               row_idx  <= eff_row;
            end

            if (beat_last && row_last) begin
               out_valid <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            // data_out is intentionally kept; the next frame overwrites it in place.
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_maxpool_flatten_buffer.sv
module tb_maxpool_flatten_buffer;
   import bnn_pkg::*;

   localparam int FRAME_BEATS = IMG_DIM * BEATS_PER_ROW;

   logic                clock;
   logic                reset;
   logic                in_valid;
   logic                in_sof;
   logic [BEAT_PIX-1:0] in_pix;
   logic                in_ready;
   pooled_vec_t         data_out;
   logic                out_valid;
   logic                out_ready;
   logic                frame_err;

   int checks = 0;
   int errors = 0;
   int err_pulses = 0;

   // Reference image; the expected map is derived from it by plain 2x2 OR-pooling.
   bit img [IMG_DIM][IMG_DIM];

   maxpool_flatten_buffer dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_pix    (in_pix),
      .in_ready  (in_ready),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(negedge clock) begin
      if (frame_err === 1'b1) err_pulses++;
   end

   // kind: 0 zeros, 1 ones, 2 single pixel (3,5), 3 even columns set, 4 sparse random
   task automatic fill_frame(input int kind);
      for (int y = 0; y < IMG_DIM; y++) begin
         for (int x = 0; x < IMG_DIM; x++) begin
            case (kind)
               0:       img[y][x] = 1'b0;
               1:       img[y][x] = 1'b1;
               2:       img[y][x] = (y == 3 && x == 5);
               3:       img[y][x] = (x % 2 == 0);
               default: img[y][x] = ($urandom_range(0, 7) == 0);
            endcase
         end
      end
   endtask

   function automatic pooled_vec_t pool_ref();
      pooled_vec_t v;
      v = '0;
      for (int r = 0; r < POOLED_DIM; r++) begin
         for (int c = 0; c < POOLED_DIM; c++) begin
            v[r*POOLED_DIM+c] = img[2*r][2*c] | img[2*r][2*c+1] |
                                img[2*r+1][2*c] | img[2*r+1][2*c+1];
         end
      end
      return v;
   endfunction

   function automatic logic [BEAT_PIX-1:0] beat_pix(input int i);
      logic [BEAT_PIX-1:0] p;
      int y;
      int b;
      y = i / BEATS_PER_ROW;
      b = i % BEATS_PER_ROW;
      for (int k = 0; k < BEAT_PIX; k++) p[k] = img[y][b*BEAT_PIX+k];
      return p;
   endfunction

   // Presents one beat and returns #1 after the edge that accepted it.
   task automatic send_beat(input logic [BEAT_PIX-1:0] p, input logic sof, input bit gaps);
      bit acc;
      bit done;
      int n;
      if (gaps) begin
         while ($urandom_range(0, 1) == 0) begin
            in_valid = 1'b0;
            in_pix   = BEAT_PIX'($urandom);
            in_sof   = 1'($urandom);
            @(posedge clock); #1;
         end
      end
      in_valid = 1'b1;
      in_pix   = p;
      in_sof   = sof;
      done = 0;
      n = 0;
      while (!done && n < 300) begin
         acc = (in_ready === 1'b1);
         @(posedge clock); #1;
         done = acc;
         n++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL beat_accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_pix   = BEAT_PIX'($urandom);
   endtask

   task automatic send_frame(input int first, input int last, input bit sof_first, input bit gaps);
      for (int i = first; i <= last; i++) send_beat(beat_pix(i), sof_first && (i == first), gaps);
   endtask

   task automatic check_frame(input string name);
      pooled_vec_t exp_map;
      exp_map = pool_ref();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_out_valid: got %b, required 1", name, out_valid);
      end
      checks++;
      if (data_out !== exp_map) begin
         errors++;
         $display("FAIL %s_data: got %h, required %h", name, data_out, exp_map);
      end
   endtask

   task automatic consume(input string name);
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_consume: out_valid=%b in_ready=%b, required 0/1", name, out_valid, in_ready);
      end
   endtask

   task automatic check_cleared(input string name);
      checks++;
      if (out_valid !== 1'b0 || data_out !== '0 || in_ready !== 1'b1 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL %s: out_valid=%b in_ready=%b frame_err=%b data_out=%h, required 0/1/0/0",
                  name, out_valid, in_ready, frame_err, data_out);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_cleared("reset_state");
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_zero_frame();
      err_pulses = 0;
      fill_frame(0);
      send_frame(0, FRAME_BEATS - 2, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_early_valid: out_valid=%b before last beat, required 0", out_valid);
      end
      send_frame(FRAME_BEATS - 1, FRAME_BEATS - 1, 1'b0, 1'b0);
      check_frame("zero");
      checks++;
      if (err_pulses != 0) begin
         errors++;
         $display("FAIL zero_frame_err: %0d pulses, required 0", err_pulses);
      end
      consume("zero");
   endtask

   task automatic test_single_pixel();
      fill_frame(2);
      send_frame(0, FRAME_BEATS - 1, 1'b1, 1'b0);
      check_frame("single");
      checks++;
      if (data_out[16] !== 1'b1 || $countones(data_out) != 1) begin
         errors++;
         $display("FAIL single_bit16: ones=%0d bit16=%b, required 1/1", $countones(data_out), data_out[16]);
      end
      consume("single");
      fill_frame(1);
      send_frame(0, FRAME_BEATS - 1, 1'b0, 1'b0);
      check_frame("all_ones");
      consume("all_ones");
   endtask

   task automatic test_backpressure();
      pooled_vec_t held;
      int stalled;
      fill_frame(4);
      send_frame(0, FRAME_BEATS - 1, 1'b1, 1'b0);
      check_frame("bp_frame1");
      held = pool_ref();
      fill_frame(3);
      in_valid = 1'b1;
      in_sof   = 1'b1;
      in_pix   = beat_pix(0);
      stalled  = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         if (in_ready !== 1'b0 || out_valid !== 1'b1) stalled++;
      end
      checks++;
      if (stalled != 0) begin
         errors++;
         $display("FAIL bp_stall: %0d cycles with in_ready=1 or out_valid=0, required 0", stalled);
      end
      checks++;
      if (data_out !== held) begin
         errors++;
         $display("FAIL bp_hold: got %h, required %h", data_out, held);
      end
      in_valid = 1'b0;
      consume("bp");
      send_frame(0, FRAME_BEATS - 1, 1'b1, 1'b0);
      check_frame("bp_frame2");
      checks++;
      if (data_out !== '1) begin
         errors++;
         $display("FAIL bp_checker_ones: got %h, required all ones", data_out);
      end
      consume("bp2");
   endtask

   task automatic test_realign();
      fill_frame(4);
      err_pulses = 0;
      send_frame(0, 49, 1'b1, 1'b0);
      fill_frame(4);
      send_frame(0, FRAME_BEATS - 1, 1'b1, 1'b0);
      check_frame("realign");
      checks++;
      if (err_pulses != 1) begin
         errors++;
         $display("FAIL realign_frame_err: %0d pulse cycles, required 1", err_pulses);
      end
      consume("realign");
   endtask

   task automatic test_async_reset();
      fill_frame(1);
      send_frame(0, 99, 1'b1, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_cleared("async_reset_midframe");
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      // No sof: the counters must already be back at the frame origin.
      fill_frame(4);
      send_frame(0, FRAME_BEATS - 1, 1'b0, 1'b0);
      check_frame("after_reset1");
      #2;
      reset = 1'b0;
      #1;
      check_cleared("async_reset_hold");
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      fill_frame(4);
      send_frame(0, FRAME_BEATS - 1, 1'b0, 1'b0);
      check_frame("after_reset2");
      consume("after_reset2");
   endtask

   task automatic test_random_gaps();
      err_pulses = 0;
      for (int f = 0; f < 3; f++) begin
         fill_frame(4);
         send_frame(0, FRAME_BEATS - 1, 1'b0, 1'b1);
         check_frame($sformatf("random%0d", f));
         consume($sformatf("random%0d", f));
      end
      checks++;
      if (err_pulses != 0) begin
         errors++;
         $display("FAIL random_frame_err: %0d pulses, required 0", err_pulses);
      end
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_pix    = '0;
      out_ready = 1'b0;
      test_reset();
      test_zero_frame();
      test_single_pixel();
      test_backpressure();
      test_realign();
      test_async_reset();
      test_random_gaps();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
